// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: BFT packet field widths, bit offsets, packet struct, state enum and pack helper
package leaf_pkt_pkg;
  localparam int PAYLOAD_BITS = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int NUM_OUT_PORTS = 2;
  localparam int FREESPACE_UPDATE_SIZE = 64;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int CREDIT_MAX = 1 << NUM_ADDR_BITS;
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic valid;
    logic [NUM_LEAF_BITS-1:0] dst_leaf;
    logic [NUM_PORT_BITS-1:0] dst_port;
    logic [NUM_ADDR_BITS-1:0] bram_addr;
    logic [PAYLOAD_BITS-1:0] payload;
  } pkt_t;
  function automatic pkt_t pack(input logic [NUM_LEAF_BITS-1:0] leaf, input logic [NUM_PORT_BITS-1:0] port,
                                input logic [NUM_ADDR_BITS-1:0] addr, input logic [PAYLOAD_BITS-1:0] payload);
    pkt_t p;
    p.valid = 1'b1;
    p.dst_leaf = leaf;
    p.dst_port = port;
    p.bram_addr = addr;
    p.payload = payload;
    return p;
  endfunction
endpackage

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot grant of the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [PW-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    // scan from the farthest offset down so the nearest request overwrites last
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/leaf_out_packetizer.sv
// leaf_out_packetizer: user-to-BFT egress, RR arbitration, packet wrap, per-port credit flow control
//   clk_user, reset (async, active-high)
//   din_leaf_user2interface / vld_user2interface / ack_interface2user : user word streams
//   cfg_wr, cfg_idx, cfg_dst : destination table write
//   credit_upd, credit_port  : freespace credit return
//   dout_leaf_interface2bft, bft_ready : packet output, MSB is valid
//   resend (only with LEAF_OUT_RESEND_EN) : re-drive the last packet that left dout
module leaf_out_packetizer
  import leaf_pkt_pkg::*;
(
  input  logic                                   clk_user,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic                                   cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]               cfg_idx,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dst,
  input  logic                                   credit_upd,
  input  logic [NUM_PORT_BITS-1:0]               credit_port,
`ifdef LEAF_OUT_RESEND_EN
  input  logic                                   resend,
`endif
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft,
  input  logic                                   bft_ready
);
  localparam int PW = NUM_OUT_PORTS > 1 ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int DST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  state_t state, state_n;
  pkt_t dout_q, pkt, rs_pkt;
  logic [DST_BITS-1:0] dst [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0] word [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0] credit [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0] credit_n [NUM_OUT_PORTS];
  logic [CREDIT_BITS:0] csum;
  logic [NUM_ADDR_BITS-1:0] addr [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cfgd, elig, arb_grant, grant;
  logic [PW-1:0] ptr, g;
  logic free, rs;
  assign free = state == EMPTY || bft_ready;
  assign grant = (free && !rs) ? arb_grant : '0;
  assign ack_interface2user = grant;
  assign dout_leaf_interface2bft = dout_q;
  rr_arbiter #(.N(NUM_OUT_PORTS), .PW(PW)) u_arb (.req(elig), .ptr(ptr), .grant(arb_grant));
  always_comb begin
    g = '0;
    csum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      word[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      elig[i] = vld_user2interface[i] && cfgd[i] && credit[i] != '0;
      if (grant[i]) g = PW'(i);
      // grant decrement and update increment net before saturating
      csum = {1'b0, credit[i]} - (CREDIT_BITS+1)'(grant[i])
           + ((credit_upd && credit_port == NUM_PORT_BITS'(i)) ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0);
      credit_n[i] = csum > (CREDIT_BITS+1)'(CREDIT_MAX) ? CREDIT_BITS'(CREDIT_MAX) : csum[CREDIT_BITS-1:0];
    end
    pkt = pack(dst[g][DST_BITS-1:NUM_PORT_BITS], dst[g][NUM_PORT_BITS-1:0], addr[g], word[g]);
  end
  always_comb begin
    state_n = (rs || |grant) ? FULL : free ? EMPTY : state;
  end
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) state <= EMPTY;
    else state <= state_n;
  end
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      ptr <= '0;
      cfgd <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dst[i] <= '0;
        credit[i] <= CREDIT_BITS'(CREDIT_MAX);
        addr[i] <= '0;
      end
    end else begin
      dout_q <= rs ? rs_pkt : |grant ? pkt : free ? '0 : dout_q;
      if (|grant) ptr <= g == PW'(NUM_OUT_PORTS - 1) ? '0 : g + 1'b1;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_n[i];
        if (grant[i]) addr[i] <= addr[i] + 1'b1;
        if (cfg_wr && cfg_idx == NUM_PORT_BITS'(i)) begin
          cfgd[i] <= 1'b1;
          dst[i] <= cfg_dst;
        end
      end
    end
  end
`ifdef LEAF_OUT_RESEND_EN
  pkt_t last, last_n;
  logic pend;
  // the packet leaving dout this cycle becomes the resend copy immediately
  assign last_n = (state == FULL && bft_ready) ? dout_q : last;
  assign rs = free && (resend || pend);
  always_comb begin
    rs_pkt = last_n;
    rs_pkt.valid = 1'b1;
  end
  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      last <= '0;
      pend <= 1'b0;
    end else begin
      last <= last_n;
      pend <= !free && (resend || pend);
    end
  end
`else
  assign rs = 1'b0;
  assign rs_pkt = '0;
`endif
endmodule
